set_job_scheduler: RTL and testbench

- Shares one SET candidate-counting engine (circle-set datapath: en/busy/valid handshake, 24-bit central, 12-bit radius, 2-bit mode, 8-bit candidate) among NREQ requesters.
- Arbitrates job requests round-robin and issues each job to the engine with a one-cycle en pulse.
- Holds the engine inputs stable until the engine returns valid, then returns the tagged result to the winning requester.
- Sits between the system job sources and the SET instance.

---
 rtl/set_job_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_set_job_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/set_job_scheduler.sv
// Round-robin front end that time-shares one SET candidate-counting engine among NREQ job sources.
// Optional engine watchdog enabled by defining SET_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request while the engine is not busy; grants the round-robin winner
// ISSUE | one-cycle set_en pulse with the latched job payload
// WAIT  | engine running; payload held until set_valid (or watchdog expiry)
// RESP  | tagged result presented to the requester until rsp_ready

module set_job_scheduler #(
   parameter int NREQ        = 4,
   parameter int IDW         = 3,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [24*NREQ-1:0]   req_central,
   input  logic [12*NREQ-1:0]   req_radius,
   input  logic [2*NREQ-1:0]    req_mode,
   output logic                 set_en,
   output logic [23:0]          set_central,
   output logic [11:0]          set_radius,
   output logic [1:0]           set_mode,
   input  logic                 set_busy,
   input  logic                 set_valid,
   input  logic [7:0]           set_candidate,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [7:0]           rsp_candidate,
   output logic                 rsp_err,
   output logic [15:0]          jobs_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [23:0]     central_q, central_d;
   logic [11:0]     radius_q, radius_d;
   logic [1:0]      mode_q, mode_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [7:0]      cand_q, cand_d;
   logic [15:0]     done_q, done_d;

   logic            grant;
   logic            found_hi;
   logic            found_lo;
   logic [IDW-1:0]  win_hi;
   logic [IDW-1:0]  win_lo;
   logic [IDW-1:0]  win_id;
   logic [23:0]     win_central;
   logic [11:0]     win_radius;
   logic [1:0]      win_mode;

`ifdef SET_TIMEOUT_EN
   logic [15:0]     tmo_q, tmo_d;
   logic            err_q, err_d;
`endif

   // Winner search: lowest valid index at or above the pointer, else lowest valid overall (wrap).
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            found_lo = 1'b1;
            win_lo   = IDW'(i);
            if (IDW'(i) >= ptr_q) begin
               found_hi = 1'b1;
               win_hi   = IDW'(i);
            end
         end
      end
      win_id = found_hi ? win_hi : win_lo;
   end

   always_comb begin
      win_central = '0;
      win_radius  = '0;
      win_mode    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_id == IDW'(i)) begin
            win_central = req_central[24*i +: 24];
            win_radius  = req_radius[12*i +: 12];
            win_mode    = req_mode[2*i +: 2];
         end
      end
   end

   // Gated with rst so nothing is offered to a requester while the block is held in reset.
   assign grant = rst && (state_q == IDLE) && !set_busy && found_lo;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = grant && (win_id == IDW'(i));
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      central_d = central_q;
      radius_d  = radius_q;
      mode_d    = mode_q;
      id_d      = id_q;
      cand_d    = cand_q;
      done_d    = done_q;
`ifdef SET_TIMEOUT_EN
      tmo_d     = tmo_q;
      err_d     = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant) begin
               central_d = win_central;
               radius_d  = win_radius;
               mode_d    = win_mode;
               id_d      = win_id;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
`ifdef SET_TIMEOUT_EN
            tmo_d   = '0;
`endif
            state_d = WAIT;
         end
         WAIT: begin
            if (set_valid) begin
               cand_d  = set_candidate;
`ifdef SET_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = RESP;
            end
`ifdef SET_TIMEOUT_EN
            else if (tmo_q == 16'(TIMEOUT_CYC - 1)) begin
               cand_d  = 8'h00;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               done_d  = done_q + 16'd1;
               ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         central_q <= '0;
         radius_q  <= '0;
         mode_q    <= '0;
         id_q      <= '0;
         cand_q    <= '0;
         done_q    <= '0;
`ifdef SET_TIMEOUT_EN
         tmo_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         central_q <= central_d;
         radius_q  <= radius_d;
         mode_q    <= mode_d;
         id_q      <= id_d;
         cand_q    <= cand_d;
         done_q    <= done_d;
`ifdef SET_TIMEOUT_EN
         tmo_q     <= tmo_d;
         err_q     <= err_d;
`endif
      end
   end

   assign set_en        = (state_q == ISSUE);
   assign rsp_valid     = (state_q == RESP);
   assign set_central   = central_q;
   assign set_radius    = radius_q;
   assign set_mode      = mode_q;
   assign rsp_id        = id_q;
   assign rsp_candidate = cand_q;
   assign jobs_done     = done_q;
`ifdef SET_TIMEOUT_EN
   assign rsp_err       = err_q;
`else
   assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_set_job_scheduler.sv
// Directed bench for set_job_scheduler: grant order, engine handshake, busy blocking,
// response backpressure, mid-job reset and the watchdog (with or without SET_TIMEOUT_EN).
module tb_set_job_scheduler;

   localparam int NREQ = 4;
   localparam int IDW  = 3;

   logic                clk;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [24*NREQ-1:0]  req_central;
   logic [12*NREQ-1:0]  req_radius;
   logic [2*NREQ-1:0]   req_mode;
   logic                set_en;
   logic [23:0]         set_central;
   logic [11:0]         set_radius;
   logic [1:0]          set_mode;
   logic                set_busy;
   logic                set_valid;
   logic [7:0]          set_candidate;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [7:0]          rsp_candidate;
   logic                rsp_err;
   logic [15:0]         jobs_done;

   int n_checks = 0;
   int n_fail   = 0;
   logic bad;

   logic [23:0] cen [NREQ];
   logic [11:0] rad [NREQ];
   logic [1:0]  mde [NREQ];

   set_job_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYC(50)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_central(req_central), .req_radius(req_radius), .req_mode(req_mode),
      .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
      .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_candidate(rsp_candidate), .rsp_err(rsp_err), .jobs_done(jobs_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_all();
      for (int i = 0; i < NREQ; i++) begin
         req_central[24*i +: 24] = cen[i];
         req_radius[12*i +: 12]  = rad[i];
         req_mode[2*i +: 2]      = mde[i];
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
      chk({tag, "_set_en"}, 32'(set_en), 32'h0);
      chk({tag, "_set_central"}, 32'(set_central), 32'h0);
      chk({tag, "_set_radius"}, 32'(set_radius), 32'h0);
      chk({tag, "_set_mode"}, 32'(set_mode), 32'h0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      chk({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
      chk({tag, "_rsp_cand"}, 32'(rsp_candidate), 32'h0);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
      chk({tag, "_jobs_done"}, 32'(jobs_done), 32'h0);
   endtask

   initial begin
      cen[0] = 24'h1A0001; cen[1] = 24'h2B0102; cen[2] = 24'h3C0203; cen[3] = 24'h4D0304;
      rad[0] = 12'h101;    rad[1] = 12'h202;    rad[2] = 12'h303;    rad[3] = 12'h404;
      mde[0] = 2'd0;       mde[1] = 2'd1;       mde[2] = 2'd2;       mde[3] = 2'd3;

      rst = 1'b0; req_valid = '0; req_central = '0; req_radius = '0; req_mode = '0;
      set_busy = 1'b0; set_valid = 1'b0; set_candidate = '0; rsp_ready = 1'b0;

      // reset state
      @(negedge clk); #1;
      chk_all_zero("reset");
      @(negedge clk); rst = 1'b1;

      // single job from requester 2, engine answers 10 cycles after set_en
      @(negedge clk);
      req_valid = 4'b0100;
      req_central[71:48] = 24'h444444; req_radius[35:24] = 12'h333; req_mode[5:4] = 2'b00;
      #1 chk("t1_grant", 32'(req_ready), 32'h4);
      chk("t1_no_en_at_grant", 32'(set_en), 32'h0);
      @(negedge clk); req_valid = '0;
      #1 chk("t1_set_en", 32'(set_en), 32'h1);
      chk("t1_ready_low", 32'(req_ready), 32'h0);
      chk("t1_central", 32'(set_central), 32'h444444);
      chk("t1_radius", 32'(set_radius), 32'h333);
      chk("t1_mode", 32'(set_mode), 32'h0);
      bad = 1'b0;
      repeat (9) begin
         @(negedge clk); #1;
         if (set_en || rsp_valid) bad = 1'b1;
      end
      chk("t1_quiet_wait", 32'(bad), 32'h0);
      @(negedge clk); set_valid = 1'b1; set_candidate = 8'd29;
      #1 chk("t1_no_rsp_yet", 32'(rsp_valid), 32'h0);
      @(negedge clk); set_valid = 1'b0; rsp_ready = 1'b1;
      #1 chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_id", 32'(rsp_id), 32'h2);
      chk("t1_rsp_cand", 32'(rsp_candidate), 32'd29);
      chk("t1_rsp_err", 32'(rsp_err), 32'h0);
      chk("t1_done_before", 32'(jobs_done), 32'h0);
      chk("t1_central_held", 32'(set_central), 32'h444444);
      @(negedge clk); rsp_ready = 1'b0;
      #1 chk("t1_rsp_drop", 32'(rsp_valid), 32'h0);
      chk("t1_done_after", 32'(jobs_done), 32'h1);

      // reset to bring the pointer back to 0 for the round-robin sweep
      @(negedge clk); rst = 1'b0;
      #1 chk("rr_reset_done", 32'(jobs_done), 32'h0);
      @(negedge clk); rst = 1'b1;
      load_all();
      rsp_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk); req_valid = 4'hF;
         #1 chk("rr_grant", 32'(req_ready), 32'(1 << (j % 4)));
         @(negedge clk);
         #1 chk("rr_set_en", 32'(set_en), 32'h1);
         chk("rr_central", 32'(set_central), 32'(cen[j % 4]));
         chk("rr_radius", 32'(set_radius), 32'(rad[j % 4]));
         chk("rr_mode", 32'(set_mode), 32'(mde[j % 4]));
         @(negedge clk); set_valid = 1'b1; set_candidate = 8'(40 + j);
         #1 chk("rr_wait", 32'(rsp_valid), 32'h0);
         @(negedge clk); set_valid = 1'b0;
         #1 chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
         chk("rr_rsp_id", 32'(rsp_id), 32'(j % 4));
         chk("rr_rsp_cand", 32'(rsp_candidate), 32'(40 + j));
      end

      // busy engine blocks the grant for 20 cycles
      @(negedge clk); req_valid = 4'b0010; set_busy = 1'b1; rsp_ready = 1'b0;
      #1 chk("busy_done", 32'(jobs_done), 32'd5);
      bad = (req_ready != 0) || set_en;
      repeat (19) begin
         @(negedge clk); #1;
         if ((req_ready != 0) || set_en) bad = 1'b1;
      end
      chk("busy_block", 32'(bad), 32'h0);
      @(negedge clk); set_busy = 1'b0;
      #1 chk("busy_release_grant", 32'(req_ready), 32'h2);

      // valid in ISSUE ignored, then response backpressure
      @(negedge clk); req_valid = 4'b1000; set_valid = 1'b1; set_candidate = 8'h77;
      #1 chk("bp_set_en", 32'(set_en), 32'h1);
      chk("bp_central", 32'(set_central), 32'(cen[1]));
      chk("bp_no_grant_issue", 32'(req_ready), 32'h0);
      @(negedge clk); set_valid = 1'b0;
      #1 chk("issue_valid_ignored", 32'(rsp_valid), 32'h0);
      @(negedge clk); set_valid = 1'b1; set_candidate = 8'hA5;
      #1 chk("bp_still_wait", 32'(rsp_valid), 32'h0);
      @(negedge clk); set_valid = 1'b0;
      #1 chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_id", 32'(rsp_id), 32'h1);
      chk("bp_rsp_cand", 32'(rsp_candidate), 32'hA5);
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk); #1;
         if (!rsp_valid || rsp_id != 3'd1 || rsp_candidate != 8'hA5 || req_ready != 0 || jobs_done != 16'd5)
            bad = 1'b1;
      end
      chk("bp_stable", 32'(bad), 32'h0);
      @(negedge clk); rsp_ready = 1'b1;
      #1 chk("bp_done_before", 32'(jobs_done), 32'd5);
      @(negedge clk); rsp_ready = 1'b0;
      #1 chk("bp_rsp_drop", 32'(rsp_valid), 32'h0);
      chk("bp_done_after", 32'(jobs_done), 32'd6);
      chk("bp_next_grant", 32'(req_ready), 32'h8);

      // reset while the engine is running
      @(negedge clk); req_valid = '0;
      #1 chk("mr_set_en", 32'(set_en), 32'h1);
      chk("mr_radius", 32'(set_radius), 32'(rad[3]));
      @(negedge clk); req_valid = 4'b0110;
      #1 chk("mr_in_wait", 32'(rsp_valid), 32'h0);
      #2 rst = 1'b0;
      #1 chk_all_zero("mr_reset");
      @(negedge clk); #1 chk("mr_hold_ready", 32'(req_ready), 32'h0);
      @(negedge clk); rst = 1'b1;
      #1 chk("mr_regrant", 32'(req_ready), 32'h2);
      @(negedge clk); req_valid = '0;
      #1 chk("mr_set_en2", 32'(set_en), 32'h1);
      chk("mr_central", 32'(set_central), 32'(cen[1]));
      @(negedge clk); set_valid = 1'b1; set_candidate = 8'd7;
      @(negedge clk); set_valid = 1'b0; rsp_ready = 1'b1;
      #1 chk("mr_rsp_id", 32'(rsp_id), 32'h1);
      chk("mr_rsp_cand", 32'(rsp_candidate), 32'd7);
      @(negedge clk); rsp_ready = 1'b0;
      #1 chk("mr_done", 32'(jobs_done), 32'h1);
      chk("mr_rsp_drop", 32'(rsp_valid), 32'h0);

      // engine that never answers
      @(negedge clk); req_valid = 4'b0100;
      #1 chk("to_grant", 32'(req_ready), 32'h4);
      @(negedge clk); req_valid = '0;
      #1 chk("to_set_en", 32'(set_en), 32'h1);
      bad = 1'b0;
      repeat (50) begin
         @(negedge clk); #1;
         if (rsp_valid) bad = 1'b1;
      end
      chk("to_quiet", 32'(bad), 32'h0);
`ifdef SET_TIMEOUT_EN
      @(negedge clk); rsp_ready = 1'b1;
      #1 chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("to_rsp_err", 32'(rsp_err), 32'h1);
      chk("to_rsp_cand", 32'(rsp_candidate), 32'h0);
      chk("to_rsp_id", 32'(rsp_id), 32'h2);
      @(negedge clk); rsp_ready = 1'b0;
      #1 chk("to_done", 32'(jobs_done), 32'h2);
      chk("to_rsp_drop", 32'(rsp_valid), 32'h0);
`else
      rsp_ready = 1'b1;
      repeat (150) begin
         @(negedge clk); #1;
         if (rsp_valid) bad = 1'b1;
      end
      chk("to_never_rsp", 32'(bad), 32'h0);
      chk("to_done", 32'(jobs_done), 32'h1);
      chk("to_err_tied", 32'(rsp_err), 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
